// File: rtl/sram_spi_rx_capture.sv
// sram_spi_rx_capture: receive side of the SRAM SPI read engine.
// Samples MISO while capture_en is high, assembles bytes MSB-first,
// and buffers them in a first-word-fall-through FIFO drained on a
// valid/ready stream. It also tracks per-frame byte count and
// raises sticky framing and overflow flags.
module sram_spi_rx_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 24
) (
    input  logic                          sclk,
    input  logic                          reset_n,
    input  logic                          miso,
    input  logic                          capture_en,
    input  logic                          clear,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              frame_bytes,
    output logic                          frame_done,
    output logic                          frag_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_END   = 2'd2
    } state_t;

    // ---------------- capture / framing state ----------------
    state_t          state_q;
    logic [6:0]      shift_q;        // up to seven already-sampled bits of the current byte
    logic [2:0]      bit_cnt_q;
    logic [CNT_W-1:0] frame_bytes_q;
    logic            frame_done_q;
    logic            frag_err_q;

    // ---------------- FIFO state ----------------
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            rd_valid_q;
    logic            overflow_q;

    logic            push;
    logic [7:0]      push_byte;
    logic            pop;
    logic            full;
    logic            wr_en;

    // A byte completes in the same cycle its eighth bit is sampled; the
    // assembled byte goes straight into the FIFO on that edge.
    assign push      = (state_q == ST_SHIFT) && capture_en && (bit_cnt_q == 3'd7) && !clear;
    assign push_byte = {shift_q, miso};

    assign pop   = rd_valid_q && rd_ready && !clear;
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    // Framing FSM: bit counting, byte completion, frame end detection.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_bytes_q <= '0;
            frame_done_q  <= 1'b0;
            frag_err_q    <= 1'b0;
        end else if (clear) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_bytes_q <= '0;
            frame_done_q  <= 1'b0;
            frag_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (capture_en) begin
                        shift_q       <= {6'd0, miso};
                        bit_cnt_q     <= 3'd1;
                        frame_bytes_q <= '0;
                        state_q       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (capture_en) begin
                        shift_q <= {shift_q[5:0], miso};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= 3'd0;
                            if (frame_bytes_q != {CNT_W{1'b1}}) begin
                                frame_bytes_q <= frame_bytes_q + CNT_W'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        // Frame ended; any partial byte is thrown away.
                        if (bit_cnt_q != 3'd0) begin
                            frag_err_q <= 1'b1;
                        end
                        bit_cnt_q    <= 3'd0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_END;
                    end
                end
                ST_END: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Next FIFO pointers/count and the look-ahead head byte, so that the
    // visible head is a plain register with no path from miso.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        if (count_d != '0) begin
            if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
                rd_data_d = push_byte;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO storage: write port only, no reset so it maps onto RAM.
    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    // FIFO control registers, head byte and overflow flag.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= (count_d != '0);
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign fifo_count  = count_q;
    assign frame_bytes = frame_bytes_q;
    assign frame_done  = frame_done_q;
    assign frag_err    = frag_err_q;
    assign overflow    = overflow_q;

endmodule
